aim_batch_scheduler: RTL and testbench

Sequencer wrapped around the AIM match engine. On a scan request it streams the whole word dictionary through the engine 32 words at a time:
- fetches each batch from the word SRAM;
- starts the engine and captures its per-word match results;
- drains every matched word as an (index, position) record on a valid/ready stream, then moves to the next batch.

It sits between the dictionary word SRAM, the AIM engine and the downstream match consumer.

---
 rtl/aim_batch_scheduler.sv | 155 +++++++++++++++
 tb/tb_aim_batch_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aim_batch_scheduler.sv
`timescale 1ns/1ps
// Streams the word dictionary through the AIM engine 32 words per batch: 33-cycle SRAM load, start pulse, wait, drain.
// Drain emits one (idx,pos) record per matched slot; a low i_res_ready freezes the record and the slot counter.
module aim_batch_scheduler #(
    parameter int W_C_BITWIDTH = 5,
    parameter int IA_CHANNEL   = 8,
    parameter int W_C_LENGTH   = 256,
    localparam int ITE_W = $clog2(IA_CHANNEL) + 1,
    localparam int AW    = $clog2(W_C_LENGTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    input  logic [ITE_W-1:0]        i_ite,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [AW:0]             o_match_cnt,
    output logic                    o_wmem_rd,
    output logic [AW-1:0]           o_wmem_addr,
    input  logic [W_C_BITWIDTH-1:0] i_wmem_rdata,
    output logic                    o_aim_start,
    output logic [ITE_W-1:0]        o_aim_ite,
    output logic [W_C_BITWIDTH-1:0] o_aim_word [0:31],
    input  logic                    i_aim_finish,
    input  logic                    i_aim_valid [0:31],
    input  logic [8:0]              i_aim_pos [0:31],
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic [AW-1:0]           o_res_idx,
    output logic [8:0]              o_res_pos
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_DRAIN, ST_DONE
    } state_t;

    localparam logic [AW-1:0] BATCH_STEP = AW'(32);
    localparam logic [AW-1:0] LAST_BASE  = AW'(W_C_LENGTH - 32);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

    state_t        state;
    logic [5:0]    k;
    logic [4:0]    s;
    logic [4:0]    s_nx;
    logic [AW-1:0] b_base;          // batch number times 32
    logic [31:0]   cap_v;
    logic [8:0]    cap_p [0:31];

    assign s_nx = s + 5'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_match_cnt <= '0;
            o_wmem_rd   <= 1'b0;
            o_wmem_addr <= '0;
            o_aim_start <= 1'b0;
            o_aim_ite   <= '0;
            o_res_valid <= 1'b0;
            o_res_idx   <= '0;
            o_res_pos   <= '0;
            k           <= '0;
            s           <= '0;
            b_base      <= '0;
            cap_v       <= '0;
            for (int i = 0; i < 32; i++) begin
                o_aim_word[i] <= '0;
                cap_p[i]      <= '0;
            end
        end else begin
            o_done      <= 1'b0;
            o_aim_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        state       <= ST_LOAD;
                        o_busy      <= 1'b1;
                        o_aim_ite   <= i_ite;
                        o_match_cnt <= '0;
                        b_base      <= '0;
                        k           <= '0;
                        o_wmem_rd   <= 1'b1;
                        o_wmem_addr <= '0;
                    end
                end
                ST_LOAD: begin
                    // read data lags the address by one cycle, so slot k-1 lands while k is issued
                    if (k != 6'd0) begin
                        o_aim_word[k[4:0] - 5'd1] <= i_wmem_rdata;
                    end
                    if (k == 6'd32) begin
                        state       <= ST_START;
                        o_aim_start <= 1'b1;
                    end else begin
                        k         <= k + 6'd1;
                        o_wmem_rd <= (k != 6'd31);
                        if (k != 6'd31) begin
                            o_wmem_addr <= b_base + AW'(k + 6'd1);
                        end
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_aim_finish) begin
                        for (int i = 0; i < 32; i++) begin
                            cap_v[i] <= i_aim_valid[i];
                            cap_p[i] <= i_aim_pos[i];
                        end
                        state       <= ST_DRAIN;
                        s           <= '0;
                        o_res_valid <= i_aim_valid[0];
                        o_res_idx   <= b_base;
                        o_res_pos   <= i_aim_pos[0];
                    end
                end
                ST_DRAIN: begin
                    // an empty slot retires immediately; a valid one waits for the handshake
                    if (!o_res_valid || i_res_ready) begin
                        if (o_res_valid) begin
                            o_match_cnt <= o_match_cnt + CNT_ONE;
                        end
                        if (s == 5'd31) begin
                            o_res_valid <= 1'b0;
                            if (b_base == LAST_BASE) begin
                                state  <= ST_DONE;
                                o_done <= 1'b1;
                            end else begin
                                state       <= ST_LOAD;
                                b_base      <= b_base + BATCH_STEP;
                                k           <= '0;
                                o_wmem_rd   <= 1'b1;
                                o_wmem_addr <= b_base + BATCH_STEP;
                            end
                        end else begin
                            s           <= s_nx;
                            o_res_valid <= cap_v[s_nx];
                            o_res_idx   <= b_base + AW'(s_nx);
                            o_res_pos   <= cap_p[s_nx];
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aim_batch_scheduler.sv
`timescale 1ns/1ps
// Randomized scoreboard bench: an engine model pushes expected records, a negedge monitor pops and compares.
module tb_aim_batch_scheduler;
    localparam int WB  = 5;
    localparam int IAC = 8;
    localparam int WL  = 256;
    localparam int ITW = 4;
    localparam int AWT = 8;
    localparam int NB  = WL / 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, req;
    logic [ITW-1:0] ite;
    logic           busy, done, wmem_rd, aim_start, res_valid, res_ready, aim_finish;
    logic [AWT:0]   match_cnt;
    logic [AWT-1:0] wmem_addr, res_idx;
    logic [WB-1:0]  rdata;
    logic [ITW-1:0] aim_ite;
    logic [WB-1:0]  aim_word [0:31];
    logic           aim_valid [0:31];
    logic [8:0]     aim_pos [0:31];
    logic [8:0]     res_pos;

    aim_batch_scheduler #(.W_C_BITWIDTH(WB), .IA_CHANNEL(IAC), .W_C_LENGTH(WL)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_ite(ite),
        .o_busy(busy), .o_done(done), .o_match_cnt(match_cnt),
        .o_wmem_rd(wmem_rd), .o_wmem_addr(wmem_addr), .i_wmem_rdata(rdata),
        .o_aim_start(aim_start), .o_aim_ite(aim_ite), .o_aim_word(aim_word),
        .i_aim_finish(aim_finish), .i_aim_valid(aim_valid), .i_aim_pos(aim_pos),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_idx(res_idx), .o_res_pos(res_pos)
    );

    typedef struct packed {
        logic [AWT-1:0] idx;
        logic [8:0]     pos;
    } rec_t;

    rec_t           exp_q[$];
    int             vectors = 0, miscompares = 0;
    logic [WB-1:0]  mem [0:WL-1];
    int             rd_cnt = 0, starts_in_scan = 0, exp_cnt = 0, eng_batch = 0, done_cnt = 0;
    int             match_mode = 0, stall_cnt = 0;
    bit             rdy_rand = 1'b0, arm_stall = 1'b0, eng_waiting = 1'b0;
    logic [ITW-1:0] exp_ite = '0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // word SRAM with one cycle of read latency
    initial begin
        logic [WB-1:0] pend;
        pend  = '0;
        rdata = '0;
        forever begin
            @(posedge clk); #1;
            rdata = pend;
            if (wmem_rd) pend = mem[wmem_addr];
        end
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (arm_stall && res_valid) begin
                arm_stall = 1'b0;
                stall_cnt = 7;
            end
            if (stall_cnt > 0) begin
                res_ready = 1'b0;
                stall_cnt--;
            end else if (rdy_rand) begin
                res_ready = ($urandom_range(0, 2) != 0);
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    function automatic bit pat_v(input int mode, input int b, input int i);
        case (mode)
            0:       return 1'b0;
            1:       return (b == 1) && (i == 0 || i == 5 || i == 31);
            2:       return 1'b1;
            default: return ($urandom_range(0, 3) == 0);
        endcase
    endfunction

    // engine model: reacts to start, optionally raises a stray finish in the start cycle
    initial begin
        int   lat, b;
        bit   v;
        logic [8:0] p;
        rec_t r;
        aim_finish = 1'b0;
        for (int i = 0; i < 32; i++) begin
            aim_valid[i] = 1'b0;
            aim_pos[i]   = '0;
        end
        forever begin
            @(posedge clk); #1;
            if (!rst && aim_start) begin
                eng_waiting = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    aim_finish = 1'b1;
                    for (int i = 0; i < 32; i++) begin
                        aim_valid[i] = 1'b1;
                        aim_pos[i]   = 9'($urandom_range(0, 511));
                    end
                end
                lat = $urandom_range(0, 5);
                @(posedge clk); #1;
                aim_finish = 1'b0;
                repeat (lat) begin
                    @(posedge clk); #1;
                end
                b = eng_batch;
                for (int i = 0; i < 32; i++) begin
                    v = pat_v(match_mode, b, i);
                    if (match_mode == 1) p = (i == 0) ? 9'd3 : (i == 5) ? 9'd40 : 9'd200;
                    else p = 9'($urandom_range(0, 511));
                    aim_valid[i] = v;
                    aim_pos[i]   = p;
                    if (v) begin
                        r.idx = AWT'(b * 32 + i);
                        r.pos = p;
                        exp_q.push_back(r);
                        exp_cnt++;
                    end
                end
                aim_finish = 1'b1;
                @(posedge clk); #1;
                aim_finish = 1'b0;
                for (int i = 0; i < 32; i++) begin
                    aim_valid[i] = 1'($urandom_range(0, 1));
                    aim_pos[i]   = 9'($urandom_range(0, 511));
                end
                eng_batch++;
                eng_waiting = 1'b0;
            end
        end
    end

    // monitor / scoreboard
    bit   prev_stall = 1'b0;
    rec_t prev_rec;
    always @(negedge clk) begin
        bit   ok;
        rec_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(res_valid), 1);
                chk("stall_idx", int'(res_idx), int'(prev_rec.idx));
                chk("stall_pos", int'(res_pos), int'(prev_rec.pos));
            end
            if (wmem_rd) begin
                chk("wmem_addr", int'(wmem_addr), rd_cnt % WL);
                rd_cnt++;
            end
            if (aim_start) begin
                starts_in_scan++;
                chk("aim_ite", int'(aim_ite), int'(exp_ite));
            end
            if (eng_waiting) begin
                ok = 1'b1;
                for (int i = 0; i < 32; i++)
                    if (aim_word[i] !== mem[(eng_batch * 32 + i) % WL]) ok = 1'b0;
                chk("aim_words", int'(ok), 1);
            end
            if (res_valid && res_ready) begin
                chk("record_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("res_idx", int'(res_idx), int'(e.idx));
                    chk("res_pos", int'(res_pos), int'(e.pos));
                end
            end
            prev_stall   = res_valid && !res_ready;
            prev_rec.idx = res_idx;
            prev_rec.pos = res_pos;
            if (done) begin
                done_cnt++;
                chk("starts_per_scan", starts_in_scan, NB);
                chk("match_cnt", int'(match_cnt), exp_cnt);
                chk("records_left", exp_q.size(), 0);
                chk("busy_at_done", int'(busy), 1);
                starts_in_scan = 0;
                exp_cnt        = 0;
                rd_cnt         = 0;
                eng_batch      = 0;
            end
        end
    end

    task automatic chk_zero(input string tag);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) if (aim_word[i] != '0) ok = 1'b0;
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_match_cnt"}, int'(match_cnt), 0);
        chk({tag, "_wmem_rd"}, int'(wmem_rd), 0);
        chk({tag, "_wmem_addr"}, int'(wmem_addr), 0);
        chk({tag, "_aim_start"}, int'(aim_start), 0);
        chk({tag, "_aim_ite"}, int'(aim_ite), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_idx"}, int'(res_idx), 0);
        chk({tag, "_res_pos"}, int'(res_pos), 0);
        chk({tag, "_words_zero"}, int'(ok), 1);
    endtask

    task automatic setup_scan(input int mode, input bit rr, input bit stall, input bit sram_mod);
        match_mode = mode;
        rdy_rand   = rr;
        arm_stall  = stall;
        for (int a = 0; a < WL; a++)
            mem[a] = sram_mod ? WB'(a % 32) : WB'($urandom_range(0, 31));
        ite     = ITW'($urandom);
        exp_ite = ite;
    endtask

    task automatic start_scan(input int mode, input bit rr, input bit stall, input bit sram_mod);
        setup_scan(mode, rr, stall, sram_mod);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("busy_after_req", int'(busy), 1);
        chk("rd_after_req", int'(wmem_rd), 1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20000);
        chk({name, "_done_seen"}, int'(done), 1);
    endtask

    task automatic finish_scan(input string name, input int exp_done);
        wait_done(name);
        repeat (5) @(negedge clk);
        chk({name, "_done_once"}, done_cnt, exp_done);
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int n, d0;
        rst = 1'b1;
        req = 1'b0;
        ite = '0;
        for (int a = 0; a < WL; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        start_scan(0, 1'b0, 1'b0, 1'b0);
        finish_scan("no_match", 1);

        start_scan(1, 1'b0, 1'b0, 1'b0);
        finish_scan("batch1", 2);

        start_scan(3, 1'b1, 1'b1, 1'b1);
        finish_scan("stall_mod32", 3);

        start_scan(2, 1'b0, 1'b0, 1'b0);
        finish_scan("full_dict", 4);

        // a request pulse during WAIT must not queue a second scan
        start_scan(3, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!eng_waiting && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait", int'(eng_waiting), 1);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        finish_scan("req_in_wait", 5);
        repeat (20) @(negedge clk);
        chk("req_in_wait_not_queued", int'(busy), 0);

        // reset in the middle of a drain
        start_scan(3, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_drain", int'(res_valid), 1);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        exp_q.delete();
        rd_cnt         = 0;
        starts_in_scan = 0;
        exp_cnt        = 0;
        eng_batch      = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        start_scan(3, 1'b1, 1'b0, 1'b0);
        finish_scan("after_abort", d0 + 1);

        // request held high through DONE restarts after one IDLE cycle
        setup_scan(3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        req = 1'b1;
        wait_done("b2b_first");
        @(negedge clk);
        chk("b2b_idle_busy", int'(busy), 0);
        @(negedge clk);
        chk("b2b_restart_busy", int'(busy), 1);
        chk("b2b_restart_rd", int'(wmem_rd), 1);
        req = 1'b0;
        finish_scan("b2b_second", d0 + 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
